// File: rtl/alu_resp_checker.sv
// ---------------------------------------------------------------------------
// alu_resp_checker
//
// Response checker for the ALU self-test stream. Every issued vector
// (a, b, sel) arrives together with the ALU's response (alu_out, alu_carry).
// The checker recomputes the expected result and counts the vector as a pass,
// a fail or a skip. Software programs the session length with num_vec and
// pulses start. done and all_pass stay set until the next start.
//
// Parameters
//   WIDTH      operand/result width in bits
//   CNT_W      width of the session target and of the pass/fail/skip counters
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse; arms a new session (restarts one in progress)
//   num_vec    session length, sampled on start (0 = finish immediately)
//   chk_valid  vector + response present this cycle
//   chk_ready  checker accepts a vector this cycle (high only while running)
//   a, b, sel  vector as issued to the ALU (sel: 00 AND, 01 OR, 10 ADD, 11 rsvd)
//   alu_out    ALU result
//   alu_carry  ALU carry (compared for ADD only)
//   busy       session in progress
//   done       session complete (sticky until start)
//   all_pass   valid while done: no fails and at least one pass
//   pass_cnt   vectors matched       (saturating)
//   fail_cnt   vectors mismatched    (saturating)
//   skip_cnt   reserved-opcode vectors (saturating)
//
// Optional build macro ALU_CHK_FIRST_FAIL_EN adds a capture of the first
// failing vector of the session:
//   ff_valid, ff_idx (0-based accept index), ff_a, ff_b, ff_sel, ff_out,
//   ff_carry
// ---------------------------------------------------------------------------
module alu_resp_checker #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             chk_valid,
   output logic             chk_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_carry,
   output logic             busy,
   output logic             done,
   output logic             all_pass,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] skip_cnt
`ifdef ALU_CHK_FIRST_FAIL_EN
   ,
   output logic             ff_valid,
   output logic [CNT_W-1:0] ff_idx,
   output logic [WIDTH-1:0] ff_a,
   output logic [WIDTH-1:0] ff_b,
   output logic [1:0]       ff_sel,
   output logic [WIDTH-1:0] ff_out,
   output logic             ff_carry
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_ADD  = 2'b10,
      OP_RSVD = 2'b11
   } op_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] acc_cnt;
   logic [CNT_W-1:0] acc_nxt;

   logic [WIDTH:0]   sum;
   logic             is_skip;
   logic             is_match;
   logic             accept;
   logic             last_accept;
   logic [CNT_W-1:0] pass_d, fail_d, skip_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
      return (en && (v != '1)) ? v + 1'b1 : v;
   endfunction

   assign chk_ready = (state_q == S_RUN);
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);

   // A start in the same cycle as a vector restarts the session, so that
   // vector belongs to the old session and is dropped.
   assign accept      = chk_ready && chk_valid && !start;
   assign acc_nxt     = acc_cnt + 1'b1;
   assign last_accept = accept && (acc_nxt == target);

   // Expected-result compare, evaluated in the accept cycle.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves it unassigned, which would otherwise infer a latch.
      sum      = {1'b0, a} + {1'b0, b};
      is_skip  = 1'b0;
      is_match = 1'b0;
      case (op_t'(sel))
         OP_AND:  is_match = (alu_out == (a & b));
         OP_OR:   is_match = (alu_out == (a | b));
         OP_ADD:  is_match = ({alu_carry, alu_out} == sum);
         default: is_skip  = 1'b1;
      endcase
   end

   always_comb begin
      pass_d = sat_inc(pass_cnt, accept && !is_skip && is_match);
      fail_d = sat_inc(fail_cnt, accept && !is_skip && !is_match);
      skip_d = sat_inc(skip_cnt, accept && is_skip);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic. start wins from any state.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = (num_vec == '0) ? S_DONE : S_RUN;
      end else if ((state_q == S_RUN) && last_accept) begin
         state_d = S_DONE;
      end
   end

   // Session datapath: target, accept count, tallies, all_pass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target   <= '0;
         acc_cnt  <= '0;
         pass_cnt <= '0;
         fail_cnt <= '0;
         skip_cnt <= '0;
         all_pass <= 1'b0;
      end else if (start) begin
         target   <= num_vec;
         acc_cnt  <= '0;
         pass_cnt <= '0;
         fail_cnt <= '0;
         skip_cnt <= '0;
         all_pass <= 1'b0;
      end else if (accept) begin
         acc_cnt  <= acc_nxt;
         pass_cnt <= pass_d;
         fail_cnt <= fail_d;
         skip_cnt <= skip_d;
         // Judged on the tallies including the final vector.
         if (last_accept) all_pass <= (fail_d == '0) && (pass_d != '0);
      end
   end

`ifdef ALU_CHK_FIRST_FAIL_EN
   // First-fail capture: loads once per session, then holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff_valid <= 1'b0;
         ff_idx   <= '0;
         ff_a     <= '0;
         ff_b     <= '0;
         ff_sel   <= '0;
         ff_out   <= '0;
         ff_carry <= 1'b0;
      end else if (start) begin
         ff_valid <= 1'b0;
         ff_idx   <= '0;
         ff_a     <= '0;
         ff_b     <= '0;
         ff_sel   <= '0;
         ff_out   <= '0;
         ff_carry <= 1'b0;
      end else if (accept && !is_skip && !is_match && !ff_valid) begin
         ff_valid <= 1'b1;
         ff_idx   <= acc_cnt;
         ff_a     <= a;
         ff_b     <= b;
         ff_sel   <= sel;
         ff_out   <= alu_out;
         ff_carry <= alu_carry;
      end
   end
`endif

endmodule

// File: tb/tb_alu_resp_checker.sv
// ---------------------------------------------------------------------------
// tb_alu_resp_checker
//
// Self-checking bench for alu_resp_checker (WIDTH=4, CNT_W=8). A directed
// table covers the AND/OR, ADD and reserved/zero-length sessions. Hand-written
// sequences cover reset/idle, flow control with restart, a full-length
// session and an asynchronous mid-run reset. A randomized phase finishes the
// run. A session-level reference model, built from plain arithmetic, tracks
// every applied cycle.
// ---------------------------------------------------------------------------
module tb_alu_resp_checker;

   localparam int W       = 4;
   localparam int CW      = 8;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [CW-1:0] num_vec;
   logic          chk_valid;
   logic          chk_ready;
   logic [W-1:0]  a, b;
   logic [1:0]    sel;
   logic [W-1:0]  alu_out;
   logic          alu_carry;
   logic          busy, done, all_pass;
   logic [CW-1:0] pass_cnt, fail_cnt, skip_cnt;
`ifdef ALU_CHK_FIRST_FAIL_EN
   logic          ff_valid;
   logic [CW-1:0] ff_idx;
   logic [W-1:0]  ff_a, ff_b, ff_out;
   logic [1:0]    ff_sel;
   logic          ff_carry;
`endif

   alu_resp_checker #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_vec   (num_vec),
      .chk_valid (chk_valid),
      .chk_ready (chk_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .alu_out   (alu_out),
      .alu_carry (alu_carry),
      .busy      (busy),
      .done      (done),
      .all_pass  (all_pass),
      .pass_cnt  (pass_cnt),
      .fail_cnt  (fail_cnt),
      .skip_cnt  (skip_cnt)
`ifdef ALU_CHK_FIRST_FAIL_EN
      ,
      .ff_valid  (ff_valid),
      .ff_idx    (ff_idx),
      .ff_a      (ff_a),
      .ff_b      (ff_b),
      .ff_sel    (ff_sel),
      .ff_out    (ff_out),
      .ff_carry  (ff_carry)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: session state expressed as plain counts.
   bit         m_running, m_finished, m_ap;
   int         m_target, m_acc, m_pass, m_fail, m_skip;
   bit         m_ffv;
   int         m_ffidx;
   logic [3:0] m_ffa, m_ffb, m_ffo;
   logic [1:0] m_ffsel;
   logic       m_ffc;

   typedef struct {
      bit         st;
      int         nv;
      bit         v;
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] sel;
      logic [3:0] o;
      bit         c;
      bit         e_rdy;
      bit         e_done;
      bit         e_ap;
      int         e_p;
      int         e_f;
      int         e_s;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_outputs(input bit rdy, input bit dn, input bit ap,
                                input int p, input int f, input int s);
      check("chk_ready", 32'(chk_ready), 32'(rdy));
      check("busy",      32'(busy),      32'(rdy));
      check("done",      32'(done),      32'(dn));
      check("all_pass",  32'(all_pass),  32'(ap));
      check("pass_cnt",  32'(pass_cnt),  32'(p));
      check("fail_cnt",  32'(fail_cnt),  32'(f));
      check("skip_cnt",  32'(skip_cnt),  32'(s));
   endtask

   task automatic check_vs_model();
      check_outputs(m_running, m_finished, m_ap, m_pass, m_fail, m_skip);
`ifdef ALU_CHK_FIRST_FAIL_EN
      check("ff_valid", 32'(ff_valid), 32'(m_ffv));
      check("ff_idx",   32'(ff_idx),   32'(m_ffidx));
      check("ff_a",     32'(ff_a),     32'(m_ffa));
      check("ff_b",     32'(ff_b),     32'(m_ffb));
      check("ff_sel",   32'(ff_sel),   32'(m_ffsel));
      check("ff_out",   32'(ff_out),   32'(m_ffo));
      check("ff_carry", 32'(ff_carry), 32'(m_ffc));
`endif
   endtask

   task automatic model_clear_ff();
      m_ffv = 0; m_ffidx = 0; m_ffa = '0; m_ffb = '0;
      m_ffsel = '0; m_ffo = '0; m_ffc = 1'b0;
   endtask

   task automatic model_reset();
      m_running = 0; m_finished = 0; m_ap = 0;
      m_target = 0; m_acc = 0; m_pass = 0; m_fail = 0; m_skip = 0;
      model_clear_ff();
   endtask

   // Correct ALU response computed with integer arithmetic.
   function automatic void ref_result(input logic [3:0] ia, input logic [3:0] ib,
                                      input logic [1:0] isel,
                                      output logic [3:0] eo, output bit ec);
      int s;
      s  = int'(ia) + int'(ib);
      ec = 0;
      case (isel)
         2'b00:   eo = ia & ib;
         2'b01:   eo = ia | ib;
         2'b10: begin eo = 4'(s % (1 << W)); ec = (s >= (1 << W)); end
         default: eo = '0;
      endcase
   endfunction

   // Drive one cycle of stimulus at the falling edge, advance the model,
   // and return 1 ns after the next rising edge.
   task automatic apply(input bit st, input int nv, input bit v,
                        input logic [3:0] ia, input logic [3:0] ib,
                        input logic [1:0] isel, input logic [3:0] io, input bit ic);
      logic [3:0] eo;
      bit         ec, ok;
      @(negedge clk);
      start = st; num_vec = 8'(nv); chk_valid = v;
      a = ia; b = ib; sel = isel; alu_out = io; alu_carry = ic;
      if (st) begin
         model_reset();
         m_target   = nv;
         m_running  = (nv != 0);
         m_finished = (nv == 0);
      end else if (m_running && v) begin
         ref_result(ia, ib, isel, eo, ec);
         ok = (io == eo) && ((isel != 2'b10) || (ic == ec));
         if (isel == 2'b11) begin
            m_skip = (m_skip < CNT_MAX) ? m_skip + 1 : CNT_MAX;
         end else if (ok) begin
            m_pass = (m_pass < CNT_MAX) ? m_pass + 1 : CNT_MAX;
         end else begin
            m_fail = (m_fail < CNT_MAX) ? m_fail + 1 : CNT_MAX;
            if (!m_ffv) begin
               m_ffv = 1; m_ffidx = m_acc; m_ffa = ia; m_ffb = ib;
               m_ffsel = isel; m_ffo = io; m_ffc = ic;
            end
         end
         m_acc++;
         if (m_acc == m_target) begin
            m_running  = 0;
            m_finished = 1;
            m_ap       = (m_fail == 0) && (m_pass != 0);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Convenience: one vector with the correct ALU response.
   task automatic apply_good(input logic [3:0] ia, input logic [3:0] ib, input logic [1:0] isel);
      logic [3:0] eo;
      bit         ec;
      ref_result(ia, ib, isel, eo, ec);
      apply(1'b0, 0, 1'b1, ia, ib, isel, eo, ec);
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ra, rb, ro, eo;
      logic [1:0] rs;
      bit         ec, rc;

      //                st    nv  v     a        b        sel    out      c     rdy   done  ap    p  f  s
      tbl[0]  = '{1'b1, 4, 1'b0, 4'h0,    4'h0,    2'b00, 4'h0,    1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};
      tbl[1]  = '{1'b0, 0, 1'b1, 4'b0011, 4'b0111, 2'b00, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0};
      tbl[2]  = '{1'b0, 0, 1'b1, 4'b1011, 4'b0110, 2'b00, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 0};
      tbl[3]  = '{1'b0, 0, 1'b1, 4'b0010, 4'b1111, 2'b01, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0, 0};
      tbl[4]  = '{1'b0, 0, 1'b1, 4'b0001, 4'b0101, 2'b01, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b1, 4, 0, 0};
      tbl[5]  = '{1'b0, 0, 1'b1, 4'h0,    4'h0,    2'b00, 4'h0,    1'b0, 1'b0, 1'b1, 1'b1, 4, 0, 0};
      tbl[6]  = '{1'b1, 3, 1'b0, 4'h0,    4'h0,    2'b00, 4'h0,    1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};
      tbl[7]  = '{1'b0, 0, 1'b1, 4'b0111, 4'b0011, 2'b10, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0};
      tbl[8]  = '{1'b0, 0, 1'b1, 4'b1011, 4'b0110, 2'b10, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 0};
      tbl[9]  = '{1'b0, 0, 1'b1, 4'b1111, 4'b0100, 2'b10, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1, 0};
      tbl[10] = '{1'b1, 2, 1'b0, 4'h0,    4'h0,    2'b00, 4'h0,    1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};
      tbl[11] = '{1'b0, 0, 1'b1, 4'h5,    4'h3,    2'b11, 4'h0,    1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1};
      tbl[12] = '{1'b0, 0, 1'b1, 4'hA,    4'h6,    2'b11, 4'h0,    1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 2};
      tbl[13] = '{1'b1, 0, 1'b0, 4'h0,    4'h0,    2'b00, 4'h0,    1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0};

      // ---- reset / idle ------------------------------------------------
      rst_n = 1'b0; start = 1'b0; num_vec = '0; chk_valid = 1'b0;
      a = '0; b = '0; sel = '0; alu_out = '0; alu_carry = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply_good(4'(i), 4'(i + 1), 2'b10);
         check_outputs(0, 0, 0, 0, 0, 0);
      end

      // ---- directed table: AND/OR, ADD, reserved, zero-length ----------
      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].st, tbl[i].nv, tbl[i].v, tbl[i].a, tbl[i].b,
               tbl[i].sel, tbl[i].o, tbl[i].c);
         check_outputs(tbl[i].e_rdy, tbl[i].e_done, tbl[i].e_ap,
                       tbl[i].e_p, tbl[i].e_f, tbl[i].e_s);
`ifdef ALU_CHK_FIRST_FAIL_EN
         if (i == 9) begin
            check("tbl_ff_valid", 32'(ff_valid), 32'd1);
            check("tbl_ff_idx",   32'(ff_idx),   32'd2);
            check("tbl_ff_a",     32'(ff_a),     32'hF);
            check("tbl_ff_b",     32'(ff_b),     32'h4);
         end
`endif
         check_vs_model();
      end

      // ---- flow control and restart ------------------------------------
      apply(1'b1, 5, 1'b0, '0, '0, 2'b00, '0, 1'b0);
      apply_good(4'h3, 4'h5, 2'b00);
      apply(1'b0, 0, 1'b0, 4'h1, 4'h1, 2'b10, 4'hF, 1'b1);  // bubble, bad data
      apply_good(4'h9, 4'h4, 2'b01);
      check_outputs(1, 0, 0, 2, 0, 0);
      // Restart with a failing vector in the same cycle: must be dropped.
      apply(1'b1, 5, 1'b1, 4'h2, 4'h2, 2'b10, 4'h0, 1'b1);
      check_outputs(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, 0, 1'b0, 4'h7, 4'h7, 2'b00, 4'h0, 1'b0);
         apply_good(4'(i + 6), 4'(3 * i), 2'b10);
         if (i == 3) check_outputs(1, 0, 0, 4, 0, 0);
      end
      check_outputs(0, 1, 1, 5, 0, 0);
      check_vs_model();

      // ---- full-length session (num_vec at its maximum) ----------------
      apply(1'b1, CNT_MAX, 1'b0, '0, '0, 2'b00, '0, 1'b0);
      for (int i = 0; i < CNT_MAX; i++) apply_good(4'($urandom), 4'($urandom), 2'($urandom_range(0, 2)));
      check_outputs(0, 1, 1, CNT_MAX, 0, 0);
      apply_good(4'h1, 4'h2, 2'b00);
      check_outputs(0, 1, 1, CNT_MAX, 0, 0);

      // ---- asynchronous reset mid-session ------------------------------
      apply(1'b1, 6, 1'b0, '0, '0, 2'b00, '0, 1'b0);
      apply_good(4'h4, 4'h4, 2'b10);
      apply(1'b0, 0, 1'b1, 4'h4, 4'h4, 2'b10, 4'h8, 1'b1);
      apply_good(4'hC, 4'h3, 2'b01);
      check_outputs(1, 0, 0, 2, 1, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs(0, 0, 0, 0, 0, 0);
      check_vs_model();
      chk_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      apply_good(4'h1, 4'h1, 2'b00);
      check_outputs(0, 0, 0, 0, 0, 0);

      // ---- randomized sessions against the model -----------------------
      for (int i = 0; i < 400; i++) begin
         ra = 4'($urandom); rb = 4'($urandom); rs = 2'($urandom);
         ref_result(ra, rb, rs, eo, ec);
         ro = ($urandom_range(0, 3) == 0) ? 4'($urandom) : eo;
         rc = ($urandom_range(0, 3) == 0) ? 1'($urandom) : ec;
         apply((i == 0) || ($urandom_range(0, 19) == 0), $urandom_range(0, 9),
               ($urandom_range(0, 3) != 0), ra, rb, rs, ro, rc);
         check_vs_model();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
